fix2sfp_pipe: RTL

Pipelined, multi-lane converter from two's-complement fixed-point accumulator results to the SFP format (sign, exponent, mantissa with hidden leading one). It sits after the Hadamard/FFT adder trees and turns each lane's summed fixed-point value, scaled by a shared block exponent, into SFP words. It has a valid/ready handshake, optional round-to-nearest-even, and explicit overflow/underflow flags.

---
 rtl/fix2sfp_pipe_if.sv | 31 +++
 rtl/fix2sfp_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fix2sfp_pipe_if.sv
// Handshake and lane-bus bundle for fix2sfp_pipe: input beat side, output beat side.
// slave is the converter's view, master is the producer/consumer view.
interface fix2sfp_pipe_if #(
    parameter int unsigned expWidth   = 4,
    parameter int unsigned sigWidth   = 4,
    parameter int unsigned low_expand = 2,
    parameter int unsigned LANES      = 4
);
    localparam int unsigned FIX_W = sigWidth + 4 + low_expand;
    localparam int unsigned FMT_W = 1 + expWidth + sigWidth;

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*FIX_W-1:0]    fixin;
    logic [expWidth-1:0]       max_exp;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*FMT_W-1:0]    sfpout;
    logic [LANES-1:0]          ovf;
    logic [LANES-1:0]          unf;

    modport master (
        output in_valid, fixin, max_exp, out_ready,
        input  in_ready, out_valid, sfpout, ovf, unf
    );

    modport slave (
        input  in_valid, fixin, max_exp, out_ready,
        output in_ready, out_valid, sfpout, ovf, unf
    );
endinterface

// File: rtl/fix2sfp_pipe.sv
// Three-stage, multi-lane two's-complement fixed-point to SFP converter with global stall.
// Define FIX2SFP_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fix2sfp_pipe #(
    parameter int unsigned expWidth   = 4,
    parameter int unsigned sigWidth   = 4,
    parameter int unsigned low_expand = 2,
    parameter int unsigned LANES      = 4
) (
    input  logic          clk,
    input  logic          rst,
    fix2sfp_pipe_if.slave bus
);
    localparam int unsigned E       = expWidth;
    localparam int unsigned M       = sigWidth;
    localparam int unsigned FIX_W   = M + 4 + low_expand;
    localparam int unsigned FMT_W   = 1 + E + M;
    localparam int unsigned PW      = $clog2(FIX_W);
    localparam int unsigned OW      = E + 2;
    localparam int unsigned EW      = E + 3;
    localparam int unsigned SHIFT_M = FIX_W - 1 - M;

    // All stages advance together; a held output freezes the whole pipe.
    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1: sign, magnitude, zero detect
    logic [LANES-1:0][FIX_W-1:0] x_c;
    logic [LANES-1:0][FIX_W-1:0] mag_c;

    always_comb begin
        x_c   = bus.fixin;
        mag_c = '0;
        for (int i = 0; i < LANES; i++) begin
            mag_c[i] = x_c[i][FIX_W-1] ? FIX_W'(-x_c[i]) : x_c[i];
        end
    end

    logic                        v1;
    logic [LANES-1:0]            s1_sign;
    logic [LANES-1:0]            s1_zero;
    logic [LANES-1:0][FIX_W-1:0] s1_mag;
    logic [E-1:0]                s1_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sign <= '0;
            s1_zero <= '0;
            s1_mag  <= '0;
            s1_exp  <= '0;
        end else if (adv) begin
            v1     <= bus.in_valid;
            s1_exp <= bus.max_exp;
            s1_mag <= mag_c;
            for (int i = 0; i < LANES; i++) begin
                s1_sign[i] <= x_c[i][FIX_W-1];
                s1_zero[i] <= (x_c[i] == '0);
            end
        end
    end

    // Stage 2: leading-one normalise, mantissa/round/sticky extraction
    logic [LANES-1:0][PW-1:0]    lead_c;
    logic [LANES-1:0][FIX_W-1:0] norm_c;
    logic [LANES-1:0][M-1:0]     mant_c;
    logic [LANES-1:0][OW-1:0]    off_c;
`ifdef FIX2SFP_RNE_EN
    logic [LANES-1:0]            rnd_c;
    logic [LANES-1:0]            stk_c;
`endif

    always_comb begin
        lead_c = '0;
        norm_c = '0;
        mant_c = '0;
        off_c  = '0;
`ifdef FIX2SFP_RNE_EN
        rnd_c  = '0;
        stk_c  = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            for (int b = 0; b < FIX_W; b++) begin
                if (s1_mag[i][b]) lead_c[i] = PW'(b);
            end
            norm_c[i] = s1_mag[i] << (PW'(FIX_W - 1) - lead_c[i]);
            mant_c[i] = M'(norm_c[i] >> SHIFT_M);
            off_c[i]  = OW'(lead_c[i]) - OW'(M - 1 + low_expand);
`ifdef FIX2SFP_RNE_EN
            rnd_c[i]  = norm_c[i][SHIFT_M-1];
            stk_c[i]  = |(norm_c[i] & FIX_W'((1 << (SHIFT_M - 1)) - 1));
`endif
        end
    end

    logic                     v2;
    logic [LANES-1:0]         s2_sign;
    logic [LANES-1:0]         s2_zero;
    logic [LANES-1:0][M-1:0]  s2_mant;
    logic [LANES-1:0][OW-1:0] s2_off;
    logic [E-1:0]             s2_exp;
`ifdef FIX2SFP_RNE_EN
    logic [LANES-1:0]         s2_rnd;
    logic [LANES-1:0]         s2_stk;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            s2_sign <= '0;
            s2_zero <= '0;
            s2_mant <= '0;
            s2_off  <= '0;
            s2_exp  <= '0;
`ifdef FIX2SFP_RNE_EN
            s2_rnd  <= '0;
            s2_stk  <= '0;
`endif
        end else if (adv) begin
            v2      <= v1;
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_mant <= mant_c;
            s2_off  <= off_c;
            s2_exp  <= s1_exp;
`ifdef FIX2SFP_RNE_EN
            s2_rnd  <= rnd_c;
            s2_stk  <= stk_c;
`endif
        end
    end

    // Stage 3: optional rounding, exponent add, saturate / flush-to-zero
    logic [LANES-1:0]            cy_c;
    logic [LANES-1:0][M-1:0]     mr_c;
    logic [LANES-1:0][EW-1:0]    e_c;
    logic [LANES-1:0][FMT_W-1:0] res_c;
    logic [LANES-1:0]            ovf_c;
    logic [LANES-1:0]            unf_c;

    always_comb begin
        cy_c  = '0;
        mr_c  = '0;
        e_c   = '0;
        res_c = '0;
        ovf_c = '0;
        unf_c = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef FIX2SFP_RNE_EN
            {cy_c[i], mr_c[i]} = (M + 1)'(s2_mant[i])
                               + (M + 1)'(s2_rnd[i] && (s2_stk[i] || s2_mant[i][0]));
`else
            mr_c[i] = s2_mant[i];
`endif
            e_c[i] = EW'(s2_exp) + {{(EW - OW){s2_off[i][OW-1]}}, s2_off[i]} + EW'(cy_c[i]);
            if (s2_zero[i]) begin
                res_c[i] = '0;
            end else if (e_c[i][EW-1]) begin
                unf_c[i] = 1'b1;
            end else if (e_c[i] > EW'((1 << E) - 1)) begin
                res_c[i] = {s2_sign[i], {E{1'b1}}, {M{1'b1}}};
                ovf_c[i] = 1'b1;
            end else begin
                res_c[i] = {s2_sign[i], e_c[i][E-1:0], mr_c[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.sfpout    <= '0;
            bus.ovf       <= '0;
            bus.unf       <= '0;
        end else if (adv) begin
            bus.out_valid <= v2;
            bus.sfpout    <= res_c;
            bus.ovf       <= ovf_c;
            bus.unf       <= unf_c;
        end
    end
endmodule
